// File: rtl/sdram_word_port.sv
// sdram_word_port
//   Upstream client adapter for one byte channel of the three-channel 8-bit
//   SDRAM controller. It takes 16-bit word requests with byte enables, splits
//   each one into one or two byte accesses on the controller's edge-triggered
//   oe/we strobes, and returns one completion per request. It also generates
//   the controller's periodic refresh request and aborts any access whose ack
//   does not complete within ACK_TIMEOUT clocks.
//
//   Ports
//     clk, reset_n           controller clock, async active-low reset
//     req_valid/req_ready    word request handshake
//     req_addr[23:0]         word address (byte address bits [24:1])
//     req_we, req_be[1:0]    write flag, byte enables (bit0 = low byte)
//     req_wdata[15:0]        write data
//     rsp_valid              one-cycle completion pulse
//     rsp_rdata[15:0]        read data, disabled lanes and writes return 0
//     rsp_err                qualifies rsp_valid, 1 = ack timeout
//     mem_addr/oe/we/din     to controller addrX/oeX/weX/dinX
//     mem_dout, mem_ack      from controller doutX/ackX
//     refresh                to controller refresh
module sdram_word_port #(
    parameter int unsigned REFRESH_INTERVAL = 1024,
    parameter int unsigned REFRESH_HOLD     = 8,
    parameter int unsigned ACK_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [24:0] mem_addr,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        refresh
);

    localparam int unsigned RC_W = $clog2(REFRESH_INTERVAL);
    localparam int unsigned HC_W = (REFRESH_HOLD > 1) ? $clog2(REFRESH_HOLD) : 1;
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT);

    localparam logic [RC_W-1:0] RC_RELOAD = RC_W'(REFRESH_INTERVAL - 1);
    localparam logic [HC_W-1:0] HC_RELOAD = HC_W'(REFRESH_HOLD - 1);
    // The strobe is already high in ISSUE and the abort passes through GAP,
    // so loading ACK_TIMEOUT-3 places the error response exactly ACK_TIMEOUT
    // clocks after the strobe rises.
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(ACK_TIMEOUT - 3);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        REFRESH
    } state_t;

    state_t state, state_n;

    logic [23:0]     addr_q;
    logic            we_q;
    logic [1:0]      be_q;
    logic [15:0]     wdata_q;
    logic            lane_q;
    logic            err_q;
    logic [15:0]     acc_q;
    logic [TO_W-1:0] to_cnt;
    logic [RC_W-1:0] ref_cnt;
    logic [HC_W-1:0] hold_cnt;
    logic            ref_pending;

    logic accept;
    logic capture;
    logic abort;
    logic next_lane;
    logic finish;
    logic strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        next_lane = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pending) begin
                    state_n = REFRESH;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_n = (req_be == 2'b00) ? GAP : ISSUE;
                end
            end
            ISSUE: state_n = WAIT_ACK;
            WAIT_ACK: begin
                if (mem_ack) begin
                    state_n = WAIT_DONE;
                end else if (to_cnt == '0) begin
                    abort   = 1'b1;
                    state_n = GAP;
                end
            end
            WAIT_DONE: begin
                // dout is registered in the same cycle ack falls
                if (!mem_ack) begin
                    capture = ~we_q;
                    state_n = GAP;
                end else if (to_cnt == '0) begin
                    abort   = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                // only be=11 reaches here with lane 0 and the high lane pending
                if (!err_q && be_q[1] && !lane_q) begin
                    next_lane = 1'b1;
                    state_n   = ISSUE;
                end else begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            REFRESH: begin
                if (hold_cnt == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            lane_q    <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            to_cnt    <= '0;
            hold_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                be_q    <= req_be;
                wdata_q <= req_wdata;
                lane_q  <= ~req_be[0] & req_be[1];
                err_q   <= 1'b0;
                acc_q   <= '0;
            end
            if (next_lane) lane_q <= 1'b1;
            if (abort)     err_q  <= 1'b1;

            if (capture) begin
                if (lane_q) acc_q[15:8] <= mem_dout;
                else        acc_q[7:0]  <= mem_dout;
            end

            if (state == ISSUE) begin
                to_cnt <= TO_RELOAD;
            end else if ((state == WAIT_ACK || state == WAIT_DONE) && to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end

            if (state == IDLE && ref_pending) begin
                hold_cnt <= HC_RELOAD;
            end else if (state == REFRESH && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            rsp_valid <= finish;
            rsp_err   <= finish & err_q;
            rsp_rdata <= finish ? acc_q : '0;
        end
    end

    // Free-running refresh timer; an expiry coinciding with the end of a
    // refresh leaves the request pending rather than losing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt     <= RC_RELOAD;
            ref_pending <= 1'b0;
        end else begin
            if (ref_cnt == '0) begin
                ref_cnt     <= RC_RELOAD;
                ref_pending <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
                if (state == REFRESH && hold_cnt == '0) ref_pending <= 1'b0;
            end
        end
    end

    // Strobes are decoded from the state register so reset clears them at once.
    assign strobe    = (state == ISSUE) || (state == WAIT_ACK) || (state == WAIT_DONE);
    assign mem_oe    = strobe & ~we_q;
    assign mem_we    = strobe & we_q;
    assign mem_addr  = {addr_q, lane_q};
    assign mem_din   = lane_q ? wdata_q[15:8] : wdata_q[7:0];
    assign refresh   = (state == REFRESH);
    assign req_ready = (state == IDLE) && !ref_pending;

endmodule

// File: tb/tb_sdram_word_port.sv
// tb_sdram_word_port
//   Directed bench for sdram_word_port. Instance dut runs with a small
//   controller model (ack latency L=3 clocks from strobe rise to ack fall);
//   instance dut_ref uses REFRESH_INTERVAL=16 for the refresh scenarios.
module tb_sdram_word_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_we;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [24:0] mem_addr;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        refresh;

    logic        r_req_valid;
    logic        r_req_ready;
    logic [23:0] r_req_addr;
    logic        r_req_we;
    logic [1:0]  r_req_be;
    logic [15:0] r_req_wdata;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [24:0] r_mem_addr;
    logic        r_mem_oe;
    logic        r_mem_we;
    logic [7:0]  r_mem_din;
    logic        r_refresh;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_word_port #(
        .REFRESH_INTERVAL(1024),
        .REFRESH_HOLD(8),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack), .refresh(refresh)
    );

    sdram_word_port #(
        .REFRESH_INTERVAL(16),
        .REFRESH_HOLD(8),
        .ACK_TIMEOUT(64)
    ) dut_ref (
        .clk(clk), .reset_n(reset_n),
        .req_valid(r_req_valid), .req_ready(r_req_ready), .req_addr(r_req_addr),
        .req_we(r_req_we), .req_be(r_req_be), .req_wdata(r_req_wdata),
        .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err),
        .mem_addr(r_mem_addr), .mem_oe(r_mem_oe), .mem_we(r_mem_we), .mem_din(r_mem_din),
        .mem_dout(8'h00), .mem_ack(1'b0), .refresh(r_refresh)
    );

    // Controller model: on a strobe rising edge, log the access; if enabled,
    // raise ack next cycle and drop it (with dout valid) L cycles after the rise.
    localparam int unsigned L = 3;
    logic        ack_en;
    logic        prev_strobe;
    logic        active;
    int unsigned m_cnt;
    logic [24:0] log_addr [0:31];
    logic        log_we   [0:31];
    logic [7:0]  log_din  [0:31];
    int          log_n = 0;

    function automatic logic [7:0] mem_byte(input logic [24:0] a);
        if (a == 25'h000200)      return 8'h34;
        else if (a == 25'h000201) return 8'h12;
        else                      return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_strobe <= 1'b0;
            active      <= 1'b0;
            mem_ack     <= 1'b0;
            mem_dout    <= 8'h00;
            m_cnt       <= 0;
        end else begin
            prev_strobe <= mem_oe | mem_we;
            if ((mem_oe | mem_we) && !prev_strobe) begin
                if (log_n < 32) begin
                    log_addr[log_n] <= mem_addr;
                    log_we[log_n]   <= mem_we;
                    log_din[log_n]  <= mem_din;
                end
                log_n <= log_n + 1;
                if (ack_en) begin
                    active  <= 1'b1;
                    mem_ack <= 1'b1;
                    m_cnt   <= 1;
                end
            end else if (active) begin
                if (m_cnt == L - 1) begin
                    mem_ack  <= 1'b0;
                    mem_dout <= mem_byte(mem_addr);
                    active   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request on dut for a single accept cycle, then watches
    // up to max_k cycles; cycle 1 is the cycle after the accepting edge.
    task automatic run_req(input logic [23:0] a, input logic we, input logic [1:0] be,
                           input logic [15:0] wd, input int max_k,
                           output int got, output logic [15:0] rd, output logic er,
                           output int strobe_cycles, output logic ready_k1);
        req_addr  = a;
        req_we    = we;
        req_be    = be;
        req_wdata = wd;
        req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
        end
        step();
        req_valid     = 1'b0;
        got           = -1;
        rd            = '0;
        er            = 1'b0;
        strobe_cycles = 0;
        ready_k1      = 1'bx;
        for (int k = 1; k <= max_k; k++) begin
            if (k == 1) ready_k1 = req_ready;
            if (mem_oe | mem_we) strobe_cycles++;
            if (rsp_valid === 1'b1 && got < 0) begin
                got = k;
                rd  = rsp_rdata;
                er  = rsp_err;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_we      = 1'b0;
        req_be      = '0;
        req_wdata   = '0;
        r_req_valid = 1'b0;
        r_req_addr  = '0;
        r_req_we    = 1'b0;
        r_req_be    = '0;
        r_req_wdata = '0;
        ack_en      = 1'b1;
        step();
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b err=%b rdata=%h expected 0/0/0000", rsp_valid, rsp_err, rsp_rdata);
        end
        n_checks++;
        if (mem_oe !== 1'b0 || mem_we !== 1'b0 || refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: oe=%b we=%b refresh=%b expected 0", mem_oe, mem_we, refresh);
        end
        n_checks++;
        if (mem_addr !== 25'h0 || mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h din=%h expected 0", mem_addr, mem_din);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_read_word();
        int got, sc, base;
        logic [15:0] rd;
        logic er, rk1;
        base = log_n;
        run_req(24'h000100, 1'b0, 2'b11, 16'h0000, 40, got, rd, er, sc, rk1);
        n_checks++;
        if (got != 11) begin n_fail++; $display("FAIL read_latency: rsp at cycle %0d expected 11", got); end
        n_checks++;
        if (rd !== 16'h1234 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data: rdata=%h err=%b expected 1234/0", rd, er);
        end
        n_checks++;
        if (log_n - base != 2) begin n_fail++; $display("FAIL read_pulses: %0d strobe pulses expected 2", log_n - base); end
        n_checks++;
        if (log_addr[base] !== 25'h000200 || log_addr[base+1] !== 25'h000201) begin
            n_fail++;
            $display("FAIL read_addr: %h then %h expected 000200 then 000201", log_addr[base], log_addr[base+1]);
        end
        n_checks++;
        if (log_we[base] !== 1'b0 || log_we[base+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_kind: we=%b,%b expected oe pulses", log_we[base], log_we[base+1]);
        end
        n_checks++;
        if (rk1 !== 1'b0) begin n_fail++; $display("FAIL read_busy_ready: req_ready=%b expected 0", rk1); end
    endtask

    task automatic test_write_high();
        int got, sc, base;
        logic [15:0] rd;
        logic er, rk1;
        base = log_n;
        run_req(24'h000010, 1'b1, 2'b10, 16'hABCD, 30, got, rd, er, sc, rk1);
        n_checks++;
        if (got != 6) begin n_fail++; $display("FAIL write_latency: rsp at cycle %0d expected 6", got); end
        n_checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp: rdata=%h err=%b expected 0000/0", rd, er);
        end
        n_checks++;
        if (log_n - base != 1) begin n_fail++; $display("FAIL write_pulses: %0d strobe pulses expected 1", log_n - base); end
        n_checks++;
        if (log_addr[base] !== 25'h000021 || log_we[base] !== 1'b1 || log_din[base] !== 8'hAB) begin
            n_fail++;
            $display("FAIL write_access: addr=%h we=%b din=%h expected 000021/1/ab",
                     log_addr[base], log_we[base], log_din[base]);
        end
    endtask

    task automatic test_be_zero();
        int got, sc, base;
        logic [15:0] rd;
        logic er, rk1;
        base = log_n;
        run_req(24'h000055, 1'b0, 2'b00, 16'h0000, 10, got, rd, er, sc, rk1);
        n_checks++;
        if (got != 2) begin n_fail++; $display("FAIL bezero_latency: rsp at cycle %0d expected 2", got); end
        n_checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL bezero_rsp: rdata=%h err=%b expected 0000/0", rd, er);
        end
        n_checks++;
        if (sc != 0 || log_n != base) begin
            n_fail++;
            $display("FAIL bezero_strobes: %0d strobe cycles, %0d pulses expected 0/0", sc, log_n - base);
        end
    endtask

    task automatic test_timeout();
        int got, sc, base;
        logic [15:0] rd;
        logic er, rk1;
        ack_en = 1'b0;
        base   = log_n;
        run_req(24'h000300, 1'b0, 2'b11, 16'h0000, 100, got, rd, er, sc, rk1);
        ack_en = 1'b1;
        n_checks++;
        if (got != 65) begin n_fail++; $display("FAIL timeout_latency: rsp at cycle %0d expected 65", got); end
        n_checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_rsp: err=%b rdata=%h expected 1/0000", er, rd);
        end
        n_checks++;
        if (sc != 63) begin n_fail++; $display("FAIL timeout_strobe_len: %0d strobe cycles expected 63", sc); end
        n_checks++;
        if (log_n - base != 1) begin n_fail++; $display("FAIL timeout_lanes: %0d strobe pulses expected 1", log_n - base); end
    endtask

    task automatic test_reset_mid();
        int got, sc;
        logic [15:0] rd;
        logic er, rk1;
        req_addr  = 24'h000040;
        req_we    = 1'b0;
        req_be    = 2'b01;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        n_checks++;
        if (mem_oe !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: mem_oe=%b expected 1", mem_oe); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_oe !== 1'b0 || rsp_valid !== 1'b0 || refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_drop: oe=%b rsp_valid=%b refresh=%b expected 0", mem_oe, rsp_valid, refresh);
        end
        step();
        step();
        reset_n = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: req_ready=%b expected 1", req_ready); end
        run_req(24'h000040, 1'b0, 2'b01, 16'h0000, 20, got, rd, er, sc, rk1);
        n_checks++;
        if (got != 6 || rd !== 16'h0025 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after: cycle %0d rdata=%h err=%b expected 6/0025/0", got, rd, er);
        end
    endtask

    task automatic test_refresh_period();
        logic exp;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            exp = (k >= 18 && k <= 25) || (k >= 34 && k <= 41) || (k >= 50 && k <= 57);
            n_checks++;
            if (r_refresh !== exp || r_mem_oe !== 1'b0 || r_mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL refresh_pattern: cycle %0d refresh=%b oe=%b we=%b expected refresh=%b",
                         k, r_refresh, r_mem_oe, r_mem_we, exp);
            end
            step();
        end
    endtask

    task automatic test_refresh_collision();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) step();
        r_req_addr  = 24'h000077;
        r_req_we    = 1'b0;
        r_req_be    = 2'b00;
        r_req_valid = 1'b1;
        for (int k = 17; k <= 25; k++) begin
            n_checks++;
            if (r_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL collide_blocked: cycle %0d req_ready=%b expected 0", k, r_req_ready);
            end
            step();
        end
        n_checks++;
        if (r_req_ready !== 1'b1 || r_refresh !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_release: req_ready=%b refresh=%b expected 1/0", r_req_ready, r_refresh);
        end
        step();
        r_req_valid = 1'b0;
        n_checks++;
        if (r_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL collide_early_rsp: rsp_valid=%b expected 0", r_rsp_valid); end
        step();
        n_checks++;
        if (r_rsp_valid !== 1'b1 || r_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_rsp: rsp_valid=%b err=%b expected 1/0", r_rsp_valid, r_rsp_err);
        end
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_write_high();
        test_be_zero();
        test_timeout();
        test_reset_mid();
        test_refresh_period();
        test_refresh_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
